// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: the frame FSM
// state encoding, the scan-code prefix bytes and a small prefix helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;

    // True for the bytes that modify the next scan code instead of being one.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
    endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Folds E0 (extended) and F0 (break) prefix bytes into a single key event
// per make/break code. A dropped frame discards any pending prefixes so a
// corrupted sequence cannot attach stale flags to the next key.
module ps2_scan_decoder
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid
);

    logic ext_pend;
    logic brk_pend;

    // Track pending prefixes and emit one registered key event per code byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_code  <= 8'h00;
            key_break <= 1'b0;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (rx_valid) begin
                if (rx_data == PS2_PREFIX_EXT) begin
                    ext_pend <= 1'b1;
                end else if (rx_data == PS2_PREFIX_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    key_code  <= rx_data;
                    key_break <= brk_pend;
                    key_ext   <= ext_pend;
                    key_valid <= 1'b1;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard front end: synchronises and de-glitches the
// pad lines, deframes 11-bit frames (start, 8 data LSB first, parity, stop),
// enforces an inter-edge timeout and hands good bytes to the scan decoder.
// Optional build macro: PS2_PARITY_CHECK_EN (odd parity enforced when set,
// parity bit sampled and ignored otherwise).
//
// Output pulse semantics: rx_valid, frame_err and key_valid are single-cycle
// strobes with no back-pressure; the consumer must take rx_data / key_* in
// the cycle the strobe is high. rx_valid and frame_err are mutually
// exclusive, and key_valid follows its code byte's rx_valid by one cycle.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER_LEN = 8
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid
);

    localparam int TMO_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYC - 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_DATA_BITS - 1);

    logic                  clk_s1, clk_s2;
    logic                  dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk, filt_clk_d;
    logic                  fall;

    ps2_state_e            state, state_d;
    logic [3:0]            bit_cnt;
    logic [7:0]            shift_reg;
    logic                  parity_bit;
    logic                  parity_ok;
    logic [TMO_W-1:0]      tmo_cnt;

    logic                  timeout;
    logic                  start_frame;
    logic                  shift_en;
    logic                  par_cap;
    logic                  stop_good;
    logic                  stop_bad;

    // Two-flop synchronisers; lines idle high so reset to 1.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Hysteresis filter: change level only after FILTER_LEN equal samples.
    always_comb begin
        filt_clk_d = filt_clk;
        if (&filt_sr) begin
            filt_clk_d = 1'b1;
        end else if (~|filt_sr) begin
            filt_clk_d = 1'b0;
        end
    end

    // Filter history, filtered clock and the registered one-cycle fall event.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            filt_sr  <= '1;
            filt_clk <= 1'b1;
            fall     <= 1'b0;
        end else begin
            filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            filt_clk <= filt_clk_d;
            fall     <= filt_clk & ~filt_clk_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data ones plus parity bit must be odd.
    assign parity_ok = ^{shift_reg, parity_bit};
`else
    // Parity bit is captured for observation but never rejects a frame.
    assign parity_ok = parity_bit | 1'b1;
`endif

    // Frame FSM next state and datapath strobes; timeout overrides a fall.
    always_comb begin
        state_d     = state;
        timeout     = 1'b0;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_cap     = 1'b0;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
        if ((state != ST_IDLE) && (tmo_cnt >= TMO_MAX)) begin
            timeout = 1'b1;
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!dat_s2) begin
                        start_frame = 1'b1;
                        state_d     = ST_DATA;
                    end
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_cap = 1'b1;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (dat_s2 && parity_ok) begin
                        stop_good = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Inter-edge watchdog: cleared by every fall and while idle, saturating.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (fall || (state == ST_IDLE)) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Shift register, bit counter, parity capture and result strobes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bit_cnt    <= 4'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= stop_good;
            frame_err <= stop_bad | timeout;
            if (start_frame) begin
                bit_cnt <= 4'd0;
            end
            if (shift_en) begin
                shift_reg <= {dat_s2, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 4'd1;
            end
            if (par_cap) begin
                parity_bit <= dat_s2;
            end
            if (stop_good) begin
                rx_data <= shift_reg;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    ps2_scan_decoder u_decoder (
        .clk       (CLOCK_50),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .key_valid (key_valid)
    );

endmodule
